// File: rtl/clock_tick_pkg.sv
// Shared defaults and width helper for the time-of-day tick generator.
package clock_tick_pkg;

  localparam int CLK_HZ_DEFAULT          = 100_000_000;
  localparam int DISPLAY_HZ_DEFAULT      = 200;
  localparam int SEC_PER_MIN_DEFAULT     = 60;
  localparam int MIN_PER_HOUR_DEFAULT    = 60;
  localparam int HOURS_PER_CYCLE_DEFAULT = 12;

  // A modulus of 1 or 2 still needs a one-bit register.
  function automatic int width_of(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIVISOR prescaler. tick is a combinational strobe meaning "wrapping at this edge";
// the parent registers it so every tick it drives out sits at the same edge as the count carries.
module tick_prescaler
  import clock_tick_pkg::*;
#(
  parameter int DIVISOR = 2
)
(
  input  logic cmosClock,
  input  logic resetN,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = width_of(DIVISOR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && !clear && (count == LAST);

  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_tick_generator.sv
// Time-of-day tick generator: registered second/minute/hour/display enables plus running counts.
// Optional macro CLOCK_TICK_SQUARE_EN adds 50%-duty square outputs that toggle on each tick.
module clock_tick_generator
  import clock_tick_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int DISPLAY_HZ      = DISPLAY_HZ_DEFAULT,
  parameter int SEC_PER_MIN     = SEC_PER_MIN_DEFAULT,
  parameter int MIN_PER_HOUR    = MIN_PER_HOUR_DEFAULT,
  parameter int HOURS_PER_CYCLE = HOURS_PER_CYCLE_DEFAULT
)
(
  input  logic cmosClock,
  input  logic resetN,
  input  logic run,
  input  logic clearSeconds,
  input  logic advMinute,
  input  logic advHour,
  output logic secondTick,
  output logic minuteTick,
  output logic hourTick,
  output logic displayTick,
  output logic [width_of(SEC_PER_MIN)-1:0]     secondCount,
  output logic [width_of(MIN_PER_HOUR)-1:0]    minuteCount,
  output logic [width_of(HOURS_PER_CYCLE)-1:0] hourCount
`ifdef CLOCK_TICK_SQUARE_EN
  ,
  output logic secondClock,
  output logic minuteClock,
  output logic hourClock,
  output logic displayClock
`endif
);

  localparam int SEC_W  = width_of(SEC_PER_MIN);
  localparam int MIN_W  = width_of(MIN_PER_HOUR);
  localparam int HOUR_W = width_of(HOURS_PER_CYCLE);

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_PER_CYCLE - 1);

  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] value);
    return (value == MIN_LAST) ? '0 : value + MIN_W'(1);
  endfunction

  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] value);
    return (value == HOUR_LAST) ? '0 : value + HOUR_W'(1);
  endfunction

  logic sec_strobe;
  logic disp_strobe;
  logic min_carry;
  logic hour_carry;
  logic [SEC_W-1:0]  sec_next;
  logic [MIN_W-1:0]  min_once;
  logic [MIN_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_once;
  logic [HOUR_W-1:0] hour_next;

  tick_prescaler #(.DIVISOR(CLK_HZ)) sec_prescaler (
    .cmosClock (cmosClock),
    .resetN    (resetN),
    .enable    (run),
    .clear     (clearSeconds),
    .tick      (sec_strobe)
  );

  tick_prescaler #(.DIVISOR(CLK_HZ / DISPLAY_HZ)) disp_prescaler (
    .cmosClock (cmosClock),
    .resetN    (resetN),
    .enable    (1'b1),
    .clear     (1'b0),
    .tick      (disp_strobe)
  );

  // Natural carries ripple through in one edge; advance pulses stack on top without carrying.
  always_comb begin
    min_carry  = sec_strobe && (secondCount == SEC_LAST);
    hour_carry = min_carry && (minuteCount == MIN_LAST);

    sec_next = secondCount;
    if (clearSeconds) begin
      sec_next = '0;
    end else if (sec_strobe) begin
      sec_next = (secondCount == SEC_LAST) ? '0 : secondCount + SEC_W'(1);
    end

    min_once  = min_carry ? min_inc(minuteCount) : minuteCount;
    min_next  = advMinute ? min_inc(min_once) : min_once;
    hour_once = hour_carry ? hour_inc(hourCount) : hourCount;
    hour_next = advHour ? hour_inc(hour_once) : hour_once;
  end

  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      secondTick  <= 1'b0;
      minuteTick  <= 1'b0;
      hourTick    <= 1'b0;
      displayTick <= 1'b0;
      secondCount <= '0;
      minuteCount <= '0;
      hourCount   <= '0;
`ifdef CLOCK_TICK_SQUARE_EN
      secondClock  <= 1'b0;
      minuteClock  <= 1'b0;
      hourClock    <= 1'b0;
      displayClock <= 1'b0;
`endif
    end else begin
      secondTick  <= sec_strobe;
      minuteTick  <= min_carry;
      hourTick    <= hour_carry;
      displayTick <= disp_strobe;
      secondCount <= sec_next;
      minuteCount <= min_next;
      hourCount   <= hour_next;
`ifdef CLOCK_TICK_SQUARE_EN
      secondClock  <= secondClock ^ sec_strobe;
      minuteClock  <= minuteClock ^ min_carry;
      hourClock    <= hourClock ^ hour_carry;
      displayClock <= displayClock ^ disp_strobe;
`endif
    end
  end

endmodule

// File: doc/clock_tick_generator.md
Name: clock_tick_generator

Overview:
- Parametrised successor to the divided-clock chain. All outputs are synchronous to the one oscillator clock.
- Produces single-cycle enable ticks (second, minute, hour, display) and the running time-of-day counts, instead of derived clocks.
- Adds run/pause, time-setting advance inputs and seconds clear.
- Sits between the oscillator pin and the hand-position/display logic, which consume the ticks as clock enables.

Parameters:
- CLK_HZ, 100000000, oscillator frequency. Must be a multiple of DISPLAY_HZ.
- DISPLAY_HZ, 200, display multiplex tick rate. CLK_HZ/DISPLAY_HZ must be ≥ 2.
- SEC_PER_MIN, 60, seconds count modulus.
- MIN_PER_HOUR, 60, minutes count modulus.
- HOURS_PER_CYCLE, 12, hours count modulus.

Ports:
- cmosClock  in  1  oscillator clock; everything clocks on its rising edge.
- resetN  in  1  asynchronous active-low reset.
- run  in  1  1 = timekeeping advances; 0 = seconds prescaler and counts frozen.
- clearSeconds  in  1  synchronous: zero the seconds prescaler and secondCount.
- advMinute  in  1  single-cycle pulse: minuteCount +1.
- advHour  in  1  single-cycle pulse: hourCount +1.
- secondTick  out  1  one-cycle pulse per elapsed second.
- minuteTick  out  1  one-cycle pulse on seconds wrap.
- hourTick  out  1  one-cycle pulse on minutes wrap.
- displayTick  out  1  one-cycle pulse at DISPLAY_HZ.
- secondCount  out  clog2(SEC_PER_MIN)  0..SEC_PER_MIN-1.
- minuteCount  out  clog2(MIN_PER_HOUR)  0..MIN_PER_HOUR-1.
- hourCount  out  clog2(HOURS_PER_CYCLE)  0..HOURS_PER_CYCLE-1.

Behaviour:
- Interface: one clock, cmosClock. Reset resetN is asynchronous, active-low.
- Reset: all prescalers, counts and tick outputs go to 0 immediately on resetN low and stay 0 while it is low. The first secondTick comes exactly CLK_HZ cycles after the first rising edge with resetN high and run=1.
- Seconds prescaler:
  - Counts 0..CLK_HZ-1, advancing only when run=1.
  - At the edge where it is at CLK_HZ-1 with run=1, it wraps to 0, secondTick is registered high for one cycle, and secondCount increments at that same edge.
- Display prescaler:
  - Counts 0..CLK_HZ/DISPLAY_HZ-1 and is free-running (ignores run and clearSeconds).
  - Same registered-pulse timing as the seconds prescaler.
- Cascade (no extra latency; all registered at the same edge):
  - secondCount wrapping SEC_PER_MIN-1 → 0 raises minuteTick in the same cycle as secondTick.
  - minuteCount wrapping MIN_PER_HOUR-1 → 0 raises hourTick in the same cycle as minuteTick.
  - hourCount wraps HOURS_PER_CYCLE-1 → 0 silently; there is no further carry.
- Tick outputs are registered, never glitching, and high for exactly one cycle.
- run=0: the seconds prescaler and all counts hold, and no second/minute/hour ticks are produced. displayTick continues.
- clearSeconds has priority over the second increment:
  - the prescaler goes to 0, secondCount goes to 0, and no ticks are generated that edge;
  - minuteCount is unaffected.
- advMinute:
  - Adds 1 mod MIN_PER_HOUR. It produces no minuteTick/hourTick and no carry into hours; it is valid whether run is 1 or 0.
  - If it coincides with a natural minute carry, minuteCount advances by 2 mod MIN_PER_HOUR. The natural hourTick fires only if the natural carry itself wraps (old value MIN_PER_HOUR-1).
- advHour: adds 1 mod HOURS_PER_CYCLE, with no tick. If it coincides with a natural hour carry, hourCount advances by 2 mod HOURS_PER_CYCLE.
- Advance inputs are level-sampled each cycle. Holding one high for N cycles advances by N; debouncing is upstream.
- Widths: every counter compare uses exact modulus constants; no count ever holds an out-of-range value.

Optional Feature:
- Macro CLOCK_TICK_SQUARE_EN.
- Defined: adds outputs secondClock, minuteClock, hourClock and displayClock.
  - Each is a registered 50%-duty square wave that toggles on every corresponding tick. It therefore inverts once per second/minute/hour/display period, so its own period is twice the tick period.
  - This keeps legacy toggling consumers working.
  - All reset to 0.
- Undefined: those ports and their registers are absent; tick behaviour is identical.

Decomposition:
- Shared package clock_tick_pkg holds:
  - default constants (CLK_HZ_DEFAULT, DISPLAY_HZ_DEFAULT, SEC_PER_MIN_DEFAULT, MIN_PER_HOUR_DEFAULT, HOURS_PER_CYCLE_DEFAULT);
  - a width function that returns clog2 with a floor of 1.
- Sub-module tick_prescaler:
  - Parameter DIVISOR; ports cmosClock, resetN, enable, clear, tick.
  - Instantiated twice: seconds and display.
- The modulo counters with carry stay inline in clock_tick_generator.

Test Plan (bench uses CLK_HZ=10, DISPLAY_HZ=5, SEC_PER_MIN=3, MIN_PER_HOUR=2, HOURS_PER_CYCLE=2):
- Release reset with run=1 → secondTick in cycles 10, 20, 30. displayTick in cycles 2, 4, 6, … secondCount sequence 1, 2, 0. minuteTick coincident with the 3rd secondTick.
- Run 120 cycles → hourTick at cycle 60. hourCount wraps to 0 at cycle 120 with no extra pulse. All ticks one cycle wide.
- run=0 for 25 cycles mid-second, at prescaler value 4 → counts and seconds prescaler frozen. displayTick still every 2 cycles. Next secondTick 6 cycles after run returns to 1.
- clearSeconds asserted in the same cycle as a pending secondTick → no tick that edge; secondCount=0; next secondTick 10 cycles later.
- advMinute pulse on the cycle of a natural minute carry with minuteCount=0 → minuteCount=0 (0+2 mod 2), minuteTick=1, hourTick=0. advHour alone from hourCount=1 → hourCount=0, hourTick=0.
- Assert resetN low asynchronously mid-count (between clock edges) → all outputs 0 before the next edge. With CLOCK_TICK_SQUARE_EN defined, secondClock toggles on each secondTick.
